// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute controller for the 8-bit SAP-2
// datapath. A registered T-state counter and a halt bit are combined with
// the current opcode and flags to produce one 16-bit control word per cycle.
// Optional build macro CTRL_VARIABLE_LENGTH_EN: when defined, each
// instruction returns to T0 right after its last active step instead of
// always running the fixed seven T-states.
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic                    flag_carry_i,
  input  logic                    flag_zero_i,
  input  logic                    flag_negative_i,
  output logic [15:0]             ctrl_word_o,
  output logic [STEP_WIDTH-1:0]   step_o,
  output logic                    halt_o
);

  typedef enum logic [STEP_WIDTH-1:0] {T0, T1, T2, T3, T4, T5, T6} step_t;

  localparam logic [STEP_WIDTH-1:0] STEP_ONE = STEP_WIDTH'(1);

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA  = OPCODE_WIDTH'(4'h1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4'h2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(4'h3);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA  = OPCODE_WIDTH'(4'h4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(4'h5);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(4'h6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC   = OPCODE_WIDTH'(4'h7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ   = OPCODE_WIDTH'(4'h8);
  localparam logic [OPCODE_WIDTH-1:0] OP_JN   = OPCODE_WIDTH'(4'h9);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUTA = OPCODE_WIDTH'(4'hE);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(4'hF);

  // Control word bit positions, MSB first.
  localparam logic [15:0] CW_HLT        = 16'h8000;
  localparam logic [15:0] CW_PC_INC     = 16'h4000;
  localparam logic [15:0] CW_PC_LOAD    = 16'h2000;
  localparam logic [15:0] CW_PC_OE      = 16'h1000;
  localparam logic [15:0] CW_MAR_LOAD   = 16'h0800;
  localparam logic [15:0] CW_RAM_OE     = 16'h0400;
  localparam logic [15:0] CW_RAM_LOAD   = 16'h0200;
  localparam logic [15:0] CW_IR_LOAD    = 16'h0100;
  localparam logic [15:0] CW_IR_OE      = 16'h0080;
  localparam logic [15:0] CW_A_LOAD     = 16'h0040;
  localparam logic [15:0] CW_A_OE       = 16'h0020;
  localparam logic [15:0] CW_B_LOAD     = 16'h0010;
  localparam logic [15:0] CW_ALU_OE     = 16'h0008;
  localparam logic [15:0] CW_ALU_SUB    = 16'h0004;
  localparam logic [15:0] CW_FLAGS_LOAD = 16'h0002;
  localparam logic [15:0] CW_OUT_LOAD   = 16'h0001;

  step_t       step_reg, step_next;
  step_t       last_step;
  logic        halt_reg, halt_next;
  logic [15:0] ctrl_word;

  // Last T-state of the current instruction; the counter wraps after it.
  always_comb begin
    last_step = T6;
`ifdef CTRL_VARIABLE_LENGTH_EN
    case (opcode_i)
      OP_LDA, OP_STA: last_step = T3;
      OP_ADD, OP_SUB: last_step = T4;
      default:        last_step = T2;
    endcase
`endif
  end

  // Next T-state and halt: HLT in T2 freezes the counter at T2 for good.
  always_comb begin
    step_next = step_reg;
    halt_next = halt_reg;
    if (halt_reg) begin
      step_next = step_reg;
    end else if (step_reg == T2 && opcode_i == OP_HLT) begin
      halt_next = 1'b1;
    end else if (step_reg == last_step) begin
      step_next = T0;
    end else begin
      step_next = step_t'(step_reg + STEP_ONE);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      step_reg <= T0;
      halt_reg <= 1'b0;
    end else begin
      step_reg <= step_next;
      halt_reg <= halt_next;
    end
  end

  // Microcode decode: word from current step, opcode and flags; silent in reset or halt.
  always_comb begin
    ctrl_word = '0;
    if (reset && !halt_reg) begin
      case (step_reg)
        T0: ctrl_word = CW_PC_OE | CW_MAR_LOAD;
        T1: ctrl_word = CW_RAM_OE | CW_IR_LOAD | CW_PC_INC;
        T2: begin
          case (opcode_i)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_word = CW_IR_OE | CW_MAR_LOAD;
            OP_LDI:  ctrl_word = CW_IR_OE | CW_A_LOAD | CW_FLAGS_LOAD;
            OP_JMP:  ctrl_word = CW_IR_OE | CW_PC_LOAD;
            OP_JC:   if (flag_carry_i)    ctrl_word = CW_IR_OE | CW_PC_LOAD;
            OP_JZ:   if (flag_zero_i)     ctrl_word = CW_IR_OE | CW_PC_LOAD;
            OP_JN:   if (flag_negative_i) ctrl_word = CW_IR_OE | CW_PC_LOAD;
            OP_OUTA: ctrl_word = CW_A_OE | CW_OUT_LOAD;
            OP_HLT:  ctrl_word = CW_HLT;
            default: ctrl_word = '0;
          endcase
        end
        T3: begin
          case (opcode_i)
            OP_LDA:         ctrl_word = CW_RAM_OE | CW_A_LOAD | CW_FLAGS_LOAD;
            OP_ADD, OP_SUB: ctrl_word = CW_RAM_OE | CW_B_LOAD;
            OP_STA:         ctrl_word = CW_A_OE | CW_RAM_LOAD;
            default:        ctrl_word = '0;
          endcase
        end
        T4: begin
          case (opcode_i)
            OP_ADD:  ctrl_word = CW_ALU_OE | CW_A_LOAD | CW_FLAGS_LOAD;
            OP_SUB:  ctrl_word = CW_ALU_OE | CW_A_LOAD | CW_FLAGS_LOAD | CW_ALU_SUB;
            default: ctrl_word = '0;
          endcase
        end
        default: ctrl_word = '0;
      endcase
    end
  end

  assign ctrl_word_o = ctrl_word;
  assign step_o      = step_reg;
  assign halt_o      = halt_reg;

endmodule
